// File: rtl/power_accumulator.sv
// Integrates ACC_LEN consecutive power spectra bin-by-bin into a ping-pong buffer and
// drains each finished block over a valid/ready stream while the next block accumulates.
module power_accumulator #(
    parameter int BITWIDTH  = 7,
    parameter int FFT_POINT = 512,
    parameter int ACC_LEN   = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_sync_in,
    input  logic [BITWIDTH+1:0]  cnt_sync_in,
    input  logic [15:0]          PowerIn,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [BITWIDTH+1:0]  acc_cnt,
    output logic [ACC_WIDTH-1:0] acc_data,
    output logic                 acc_last,
    output logic                 overflow,
    output logic                 sync_err
);

    localparam int CW = BITWIDTH + 2;
    localparam int SW = $clog2(ACC_LEN);
    localparam logic [CW-1:0] LAST_BIN  = CW'(FFT_POINT - 1);
    localparam logic [SW-1:0] LAST_SPEC = SW'(ACC_LEN - 1);

    typedef enum logic {WAIT_SYNC, ACCUM} wr_state_t;
    typedef enum logic {IDLE, DRAIN} dr_state_t;

    // Both halves of the ping-pong live in one array, addressed as {buffer, bin}.
    logic [ACC_WIDTH-1:0] mem [2*FFT_POINT];

    // Write side state
    wr_state_t      wr_state;
    logic [SW-1:0]  spec_cnt;
    logic [CW-1:0]  prev_cnt;
    logic           wr_buf;

    // RMW stage-1 registers (read issued at accept, add/write one cycle later)
    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_buf;
    logic                 s1_handover;
    logic [CW-1:0]        s1_addr;
    logic [15:0]          s1_power;
    logic [ACC_WIDTH-1:0] rmw_q;
    logic [ACC_WIDTH-1:0] s1_ext;

    // Drain side state
    dr_state_t            dr_state;
    logic                 dr_buf;
    logic [CW-1:0]        rd_addr;
    logic                 rd_pending;
    logic                 q_valid;
    logic [CW-1:0]        q_cnt;
    logic [ACC_WIDTH-1:0] q_data;

    // Combinational control
    logic [CW-1:0] next_cnt;
    logic [SW-1:0] cur_spec;
    logic          accept;
    logic          mismatch;
    logic          restart;
    logic          block_end;
    logic          buf_free;
    logic          drain_release;
    logic          b_load;
    logic          a_adv;
    logic          issue;

    assign s1_ext = ACC_WIDTH'(s1_power);

    always_comb begin
        next_cnt  = (prev_cnt == LAST_BIN) ? '0 : prev_cnt + CW'(1);
        accept    = 1'b0;
        mismatch  = 1'b0;
        restart   = 1'b0;
        if (en_sync_in) begin
            if (wr_state == WAIT_SYNC) begin
                accept = (cnt_sync_in == '0);
            end else if (cnt_sync_in == next_cnt) begin
                accept = 1'b1;
            end else begin
                // A broken sequence that lands on bin 0 starts a new block at once.
                mismatch = 1'b1;
                restart  = (cnt_sync_in == '0);
                accept   = restart;
            end
        end
        cur_spec  = restart ? '0 : spec_cnt;
        block_end = accept && (cnt_sync_in == LAST_BIN) && (cur_spec == LAST_SPEC);
    end

    // Valid/ready: a beat transfers on a rising clk edge where acc_valid && acc_ready;
    // while acc_valid && !acc_ready the beat (data/cnt/last) is held unchanged.
    assign drain_release = acc_valid && acc_ready && acc_last;
    assign buf_free      = (dr_state == IDLE) || drain_release;
    assign b_load        = !acc_valid || acc_ready;
    assign a_adv         = !q_valid || b_load;
    assign issue         = (dr_state == DRAIN) && rd_pending && a_adv;

    // Write FSM and RMW pipeline control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state    <= WAIT_SYNC;
            spec_cnt    <= '0;
            prev_cnt    <= '0;
            wr_buf      <= 1'b0;
            sync_err    <= 1'b0;
            overflow    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_first    <= 1'b0;
            s1_buf      <= 1'b0;
            s1_addr     <= '0;
            s1_power    <= '0;
            s1_handover <= 1'b0;
        end else begin
            s1_valid    <= accept;
            s1_handover <= block_end && buf_free;
            if (accept) begin
                s1_addr  <= cnt_sync_in;
                s1_buf   <= wr_buf;
                s1_first <= (cur_spec == '0);
                s1_power <= PowerIn;
                prev_cnt <= cnt_sync_in;
            end
            if (mismatch) begin
                sync_err <= 1'b1;
            end
            if (mismatch && !accept) begin
                wr_state <= WAIT_SYNC;
                spec_cnt <= '0;
            end else if (accept) begin
                wr_state <= ACCUM;
                if (block_end) begin
                    spec_cnt <= '0;
                    if (buf_free) begin
                        wr_buf <= ~wr_buf;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (cnt_sync_in == LAST_BIN) begin
                    spec_cnt <= cur_spec + SW'(1);
                end else begin
                    spec_cnt <= cur_spec;
                end
            end
        end
    end

    // Buffer RAM: RMW read, RMW write, drain read
    always_ff @(posedge clk) begin
        if (accept) begin
            rmw_q <= mem[{wr_buf, cnt_sync_in}];
        end
        if (s1_valid) begin
            mem[{s1_buf, s1_addr}] <= s1_first ? s1_ext : rmw_q + s1_ext;
        end
        if (issue) begin
            q_data <= mem[{dr_buf, rd_addr}];
        end
    end

    // Drain FSM with RAM-read stage and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dr_state   <= IDLE;
            dr_buf     <= 1'b0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            q_valid    <= 1'b0;
            q_cnt      <= '0;
            acc_valid  <= 1'b0;
            acc_cnt    <= '0;
            acc_data   <= '0;
            acc_last   <= 1'b0;
        end else begin
            case (dr_state)
                IDLE: begin
                    if (s1_handover) begin
                        dr_state   <= DRAIN;
                        dr_buf     <= s1_buf;
                        rd_addr    <= '0;
                        rd_pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_release) begin
                        dr_state <= IDLE;
                    end
                end
                default: dr_state <= IDLE;
            endcase
            if (issue) begin
                rd_addr <= rd_addr + CW'(1);
                if (rd_addr == LAST_BIN) begin
                    rd_pending <= 1'b0;
                end
            end
            if (a_adv) begin
                q_valid <= issue;
                if (issue) begin
                    q_cnt <= rd_addr;
                end
            end
            if (b_load) begin
                acc_valid <= q_valid;
                if (q_valid) begin
                    acc_cnt  <= q_cnt;
                    acc_data <= q_data;
                    acc_last <= (q_cnt == LAST_BIN);
                end
            end
        end
    end

endmodule
